traffic_state_ctrl: RTL and testbench

TRAFFIC_STATE_CTRL -- requirements
Module: traffic_state_ctrl

---
 rtl/traffic_state_ctrl.sv | 106 ++++++++++
 tb/tb_traffic_state_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/traffic_state_ctrl.sv
// rtl/traffic_state_ctrl.sv - two-way traffic light phase sequencer with
// a one-second prescaler, per-direction countdowns and a hold input.
`timescale 1ns/1ps
module traffic_state_ctrl #(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int GREEN_TIME  = 27,
  parameter int YELLOW_TIME = 3
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       hold,
  output logic [1:0] state,
  output logic [5:0] ew_time,
  output logic [5:0] ns_time,
  output logic       sec_tick
);

  typedef enum logic [1:0] {
    NS_GREEN  = 2'b00,
    NS_YELLOW = 2'b01,
    EW_GREEN  = 2'b10,
    EW_YELLOW = 2'b11
  } phase_t;

  localparam int              CNT_W   = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_FREQ - 1);
  localparam logic [5:0]      T_G     = 6'(GREEN_TIME);
  localparam logic [5:0]      T_Y     = 6'(YELLOW_TIME);
  localparam logic [5:0]      T_GY    = 6'(GREEN_TIME + YELLOW_TIME);

  logic [CNT_W-1:0] presc;
  logic             tick;
  phase_t           phase_q, phase_d;
  logic [5:0]       ew_d, ns_d;
  logic [5:0]       run_time;

  // The tick fires on the edge that completes a full unheld second, so the
  // phase update and the registered sec_tick pulse appear together.
  assign tick = !hold && (presc == CNT_MAX);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      presc    <= '0;
      sec_tick <= 1'b0;
    end else begin
      sec_tick <= tick;
      if (!hold) begin
        presc <= (presc == CNT_MAX) ? '0 : presc + 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      phase_q <= NS_GREEN;
      ns_time <= T_G;
      ew_time <= T_GY;
    end else begin
      phase_q <= phase_d;
      ns_time <= ns_d;
      ew_time <= ew_d;
    end
  end

  // NS runs in the 0x phases, EW in the 1x phases.
  assign run_time = phase_q[1] ? ew_time : ns_time;

  always_comb begin
    phase_d = phase_q;
    ew_d    = ew_time;
    ns_d    = ns_time;
    if (tick) begin
      if (run_time != 6'd1) begin
        ew_d = ew_time - 6'd1;
        ns_d = ns_time - 6'd1;
      end else begin
        unique case (phase_q)
          NS_GREEN: begin
            phase_d = NS_YELLOW;
            ns_d    = T_Y;
            ew_d    = ew_time - 6'd1;
          end
          NS_YELLOW: begin
            phase_d = EW_GREEN;
            ew_d    = T_G;
            ns_d    = T_GY;
          end
          EW_GREEN: begin
            phase_d = EW_YELLOW;
            ew_d    = T_Y;
            ns_d    = ns_time - 6'd1;
          end
          EW_YELLOW: begin
            phase_d = NS_GREEN;
            ns_d    = T_G;
            ew_d    = T_GY;
          end
          default: phase_d = NS_GREEN;
        endcase
      end
    end
  end

  assign state = phase_q;

endmodule

// File: tb/tb_traffic_state_ctrl.sv
// tb/tb_traffic_state_ctrl.sv - self-checking bench for traffic_state_ctrl
// with CLK_FREQ=10, GREEN_TIME=5, YELLOW_TIME=2.
`timescale 1ns/1ps
module tb_traffic_state_ctrl;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       hold    = 1'b0;
  logic [1:0] state;
  logic [5:0] ew_time;
  logic [5:0] ns_time;
  logic       sec_tick;

  traffic_state_ctrl #(.CLK_FREQ(10), .GREEN_TIME(5), .YELLOW_TIME(2)) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .hold     (hold),
    .state    (state),
    .ew_time  (ew_time),
    .ns_time  (ns_time),
    .sec_tick (sec_tick)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int         cycles;
    logic       hold_in;
    logic [1:0] st;
    logic [5:0] ew;
    logic [5:0] ns;
  } vec_t;

  vec_t vecs[14];
  vec_t sb_q[$];

  int compared   = 0;
  int mismatched = 0;
  int unheld_cnt = 0;
  int tick_count = 0;
  logic [1:0] prev_st;
  logic [5:0] prev_ew, prev_ns;

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge sys_clk);
    @(negedge sys_clk);
    #1;
  endtask

  // Unheld active edges since the previous tick; a tick must land on the 10th.
  always @(posedge sys_clk) begin
    if (!sys_rst && !hold) unheld_cnt++;
  end

  always @(negedge sys_clk) begin
    if (!sys_rst) begin
      chk("bounds", int'(ew_time >= 1 && ew_time <= 7 && ns_time >= 1 && ns_time <= 7), 1);
      if (!sec_tick) begin
        chk("no_change_without_tick", int'({state, ew_time, ns_time} == {prev_st, prev_ew, prev_ns}), 1);
      end else begin
        tick_count++;
        chk("legal_seq", int'(state == prev_st || state == prev_st + 2'd1), 1);
        chk("tick_spacing", unheld_cnt, 10);
        unheld_cnt = 0;
        if (sb_q.size() == 0) begin
          chk("unexpected_tick", 1, 0);
        end else begin
          vec_t e;
          e = sb_q.pop_front();
          chk("tick_state", int'(state), int'(e.st));
          chk("tick_ew_time", int'(ew_time), int'(e.ew));
          chk("tick_ns_time", int'(ns_time), int'(e.ns));
        end
      end
    end
    prev_st = state;
    prev_ew = ew_time;
    prev_ns = ns_time;
  end

  task automatic push_run(input int idx);
    sb_q.push_back(vecs[idx]);
    hold = vecs[idx].hold_in;
    run(vecs[idx].cycles);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int tc;
    logic [1:0] s0;
    logic [5:0] e0, n0;

    // Expected outputs after each tick of one full 140-cycle rotation.
    vecs[0]  = '{10, 1'b0, 2'd0, 6'd6, 6'd4};
    vecs[1]  = '{10, 1'b0, 2'd0, 6'd5, 6'd3};
    vecs[2]  = '{10, 1'b0, 2'd0, 6'd4, 6'd2};
    vecs[3]  = '{10, 1'b0, 2'd0, 6'd3, 6'd1};
    vecs[4]  = '{10, 1'b0, 2'd1, 6'd2, 6'd2};
    vecs[5]  = '{10, 1'b0, 2'd1, 6'd1, 6'd1};
    vecs[6]  = '{10, 1'b0, 2'd2, 6'd5, 6'd7};
    vecs[7]  = '{10, 1'b0, 2'd2, 6'd4, 6'd6};
    vecs[8]  = '{10, 1'b0, 2'd2, 6'd3, 6'd5};
    vecs[9]  = '{10, 1'b0, 2'd2, 6'd2, 6'd4};
    vecs[10] = '{10, 1'b0, 2'd2, 6'd1, 6'd3};
    vecs[11] = '{10, 1'b0, 2'd3, 6'd2, 6'd2};
    vecs[12] = '{10, 1'b0, 2'd3, 6'd1, 6'd1};
    vecs[13] = '{10, 1'b0, 2'd0, 6'd7, 6'd5};

    run(3);
    chk("reset_state", int'(state), 0);
    chk("reset_ns_time", int'(ns_time), 5);
    chk("reset_ew_time", int'(ew_time), 7);
    chk("reset_sec_tick", int'(sec_tick), 0);
    sys_rst = 1'b0;
    unheld_cnt = 0;

    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < 14; i++) begin
        push_run(i);
        if (c == 0 && i == 4) chk("ticks_in_first_50", tick_count, 5);
      end
    end
    chk("three_rotations_ticks", tick_count, 42);

    // Hold for 25 cycles starting 4 cycles into a second.
    run(4);
    s0 = state; e0 = ew_time; n0 = ns_time; tc = tick_count;
    hold = 1'b1;
    run(25);
    chk("hold_state", int'(state), int'(s0));
    chk("hold_ew_time", int'(ew_time), int'(e0));
    chk("hold_ns_time", int'(ns_time), int'(n0));
    chk("hold_no_tick", tick_count, tc);
    hold = 1'b0;
    sb_q.push_back(vecs[0]);
    run(5);
    chk("release_tick_not_early", tick_count, tc);
    run(1);
    chk("release_tick_after_6", tick_count, tc + 1);

    for (int i = 1; i < 13; i++) push_run(i);
    chk("pre_reset_state", int'(state), 3);
    chk("pre_reset_ew_time", int'(ew_time), 1);

    // Asynchronous reset between clock edges in state 11, ew_time=1.
    run(3);
    #1;
    sys_rst = 1'b1;
    #1;
    chk("async_rst_state", int'(state), 0);
    chk("async_rst_ns_time", int'(ns_time), 5);
    chk("async_rst_ew_time", int'(ew_time), 7);
    chk("async_rst_sec_tick", int'(sec_tick), 0);
    chk("queue_empty_before_rst", sb_q.size(), 0);
    run(2);
    sys_rst = 1'b0;
    unheld_cnt = 0;
    tc = tick_count;
    sb_q.push_back(vecs[0]);
    run(9);
    chk("first_tick_not_early", tick_count, tc);
    run(1);
    chk("first_tick_after_rst", tick_count, tc + 1);

    // Hold asserted while the prescaler sits at its last count.
    run(9);
    tc = tick_count;
    hold = 1'b1;
    run(3);
    chk("hold_at_max_no_tick", tick_count, tc);
    hold = 1'b0;
    sb_q.push_back(vecs[1]);
    run(1);
    chk("hold_at_max_tick_on_release", tick_count, tc + 1);

    run(2);
    chk("queue_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
